inst_mem: RTL and testbench

INST_MEM -- requirements
Module: inst_mem

---
 rtl/inst_mem_pkg.sv | 16 +
 rtl/inst_mem_array.sv | 38 +++
 rtl/inst_mem.sv | 150 +++++++++++++++
 tb/tb_inst_mem.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_mem_pkg.sv
// Shared types and constants for the instruction memory.
// Holds the load FSM encoding and the default NOP word.
package inst_mem_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2
  } state_t;

  // Wide enough for any practical instruction width.
  localparam int NOP_MAX_W = 64;

  localparam logic [NOP_MAX_W-1:0] DEFAULT_NOP = '0;

endpackage

// File: rtl/inst_mem_array.sv
// Instruction storage: one synchronous write port and
// one registered read port. Contents are never reset.
module inst_mem_array #(
  parameter int A = 10,
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [A-1:0] wr_addr,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  input  logic [A-1:0] rd_addr,
  output logic [W-1:0] rd_data
);

  localparam int DEPTH = 1 << A;

  logic [W-1:0] mem [DEPTH];

  // Store a word on the write strobe; no reset on storage.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read register only moves on an enabled read, so it
  // holds the last fetched word between fetches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/inst_mem.sv
// Loadable instruction memory with a one-cycle fetch port.
// Load FSM, write pointer and fetch bounds check live here.
module inst_mem
  import inst_mem_pkg::*;
#(
  parameter int           A   = 10,
  parameter int           W   = 9,
  parameter logic [W-1:0] NOP = DEFAULT_NOP[W-1:0]
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         LoadStart,
  input  logic         LoadValid,
  input  logic [W-1:0] LoadData,
  input  logic         LoadLast,
  output logic         LoadBusy,
  input  logic         FetchReq,
  input  logic [A-1:0] FetchAddr,
  output logic         FetchReady,
  output logic         FetchValid,
  output logic [W-1:0] FetchData,
  output logic         FetchFault,
  output logic [A:0]   ProgLen
);

  state_t       state;
  state_t       state_nxt;
  logic [A-1:0] ptr;
  logic [A:0]   prog_len;
  logic         wr_en;
  logic         at_top;
  logic         accept;
  logic         in_range;
  logic         nop_sel;
  logic [W-1:0] rd_data;

  assign at_top   = (ptr == {A{1'b1}});
  assign accept   = FetchReq && FetchReady;
  assign in_range = ({1'b0, FetchAddr} < prog_len);

  // FSM state register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: LoadStart always (re)enters LOAD; a load
  // ends on a qualified last word or on the top address.
  always_comb begin
    state_nxt = state;
    unique case (state)
      EMPTY: begin
        if (LoadStart) begin
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        if (LoadStart) begin
          state_nxt = LOAD;
        end else if (LoadValid && (LoadLast || at_top)) begin
          state_nxt = READY;
        end
      end
      READY: begin
        if (LoadStart) begin
          state_nxt = LOAD;
        end
      end
      default: begin
        state_nxt = EMPTY;
      end
    endcase
  end

  // FSM outputs: a restart in LOAD drops that cycle's word,
  // and LoadStart blocks fetch acceptance.
  always_comb begin
    LoadBusy   = 1'b0;
    FetchReady = 1'b0;
    wr_en      = 1'b0;
    unique case (state)
      LOAD: begin
        LoadBusy = 1'b1;
        wr_en    = LoadValid && !LoadStart;
      end
      READY: begin
        FetchReady = !LoadStart;
      end
      default: begin
        LoadBusy = 1'b0;
      end
    endcase
  end

  // Write pointer and program length; the pointer parks
  // at the top address rather than wrapping.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ptr      <= '0;
      prog_len <= '0;
    end else if (LoadStart) begin
      ptr      <= '0;
      prog_len <= '0;
    end else if (wr_en) begin
      if (!at_top) begin
        ptr <= ptr + A'(1);
      end
      if (LoadLast || at_top) begin
        prog_len <= (A + 1)'(ptr) + (A + 1)'(1);
      end
    end
  end

  // Fetch response flags; nop_sel only changes on an
  // accept so FetchData holds across idle cycles.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      FetchValid <= 1'b0;
      FetchFault <= 1'b0;
      nop_sel    <= 1'b0;
    end else begin
      FetchValid <= accept;
      FetchFault <= accept && !in_range;
      if (accept) begin
        nop_sel <= !in_range;
      end
    end
  end

  inst_mem_array #(
    .A(A),
    .W(W)
  ) u_array (
    .clk     (Clk),
    .rst_n   (Reset_n),
    .wr_en   (wr_en),
    .wr_addr (ptr),
    .wr_data (LoadData),
    .rd_en   (accept),
    .rd_addr (FetchAddr),
    .rd_data (rd_data)
  );

  assign FetchData = nop_sel ? NOP : rd_data;
  assign ProgLen   = prog_len;

endmodule

// File: tb/tb_inst_mem.sv
// Self-checking bench for inst_mem (default and A=2 builds).
// Randomised loads and fetches against an array model.
module tb_inst_mem;

  localparam int A  = 10;
  localparam int W  = 9;
  localparam int SA = 2;

  logic         Clk = 1'b0;
  logic         Reset_n = 1'b0;

  logic         ld_start, ld_valid, ld_last;
  logic [W-1:0] ld_data;
  logic         busy;
  logic         f_req;
  logic [A-1:0] f_addr;
  logic         f_ready, f_valid, f_fault;
  logic [W-1:0] f_data;
  logic [A:0]   plen;

  logic          s_ld_start, s_ld_valid, s_ld_last;
  logic [W-1:0]  s_ld_data;
  logic          s_busy;
  logic          s_f_req;
  logic [SA-1:0] s_f_addr;
  logic          s_f_ready, s_f_valid, s_f_fault;
  logic [W-1:0]  s_f_data;
  logic [SA:0]   s_plen;

  int checks = 0;
  int failures = 0;

  logic [W-1:0] mdl_mem [1 << A];
  int           mdl_len = 0;
  logic [W-1:0] mdl_last = '0;
  logic [W-1:0] words [$];

  inst_mem #(.A(A), .W(W)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .LoadStart(ld_start), .LoadValid(ld_valid),
    .LoadData(ld_data), .LoadLast(ld_last),
    .LoadBusy(busy),
    .FetchReq(f_req), .FetchAddr(f_addr),
    .FetchReady(f_ready), .FetchValid(f_valid),
    .FetchData(f_data), .FetchFault(f_fault),
    .ProgLen(plen)
  );

  inst_mem #(.A(SA), .W(W)) dut_small (
    .Clk(Clk), .Reset_n(Reset_n),
    .LoadStart(s_ld_start), .LoadValid(s_ld_valid),
    .LoadData(s_ld_data), .LoadLast(s_ld_last),
    .LoadBusy(s_busy),
    .FetchReq(s_f_req), .FetchAddr(s_f_addr),
    .FetchReady(s_f_ready), .FetchValid(s_f_valid),
    .FetchData(s_f_data), .FetchFault(s_f_fault),
    .ProgLen(s_plen)
  );

  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    ld_start = 0; ld_valid = 0; ld_last = 0; ld_data = '0;
    f_req = 0; f_addr = '0;
    s_ld_start = 0; s_ld_valid = 0; s_ld_last = 0;
    s_ld_data = '0; s_f_req = 0; s_f_addr = '0;
  endtask

  task automatic do_load(input bit use_last, input bit gaps);
    int i;
    ld_start = 1;
    tick();
    ld_start = 0;
    checks++;
    if (busy !== 1'b1 || plen !== '0) begin
      failures++;
      $display("FAIL load_enter busy=%0b plen=%0d exp busy=1 plen=0",
               busy, plen);
    end
    i = 0;
    while (i < words.size()) begin
      if (gaps && ($urandom % 4 == 0)) begin
        ld_valid = 0;
        ld_last = 1'($urandom);
        ld_data = W'($urandom);
      end else begin
        ld_valid = 1;
        ld_data = words[i];
        ld_last = use_last && (i == words.size() - 1);
        i++;
      end
      tick();
    end
    ld_valid = 0;
    ld_last = 0;
    for (int k = 0; k < words.size(); k++) mdl_mem[k] = words[k];
    mdl_len = words.size();
    checks++;
    if (busy !== 1'b0 || plen !== (A + 1)'(mdl_len)) begin
      failures++;
      $display("FAIL load_done busy=%0b plen=%0d exp busy=0 plen=%0d",
               busy, plen, mdl_len);
    end
  endtask

  task automatic fetch(input int a);
    logic [W-1:0] exp_d;
    logic         exp_f;
    f_req = 1;
    f_addr = a[A-1:0];
    #1;
    checks++;
    if (f_ready !== 1'b1) begin
      failures++;
      $display("FAIL fetch_ready addr=%0d got=%0b exp=1", a, f_ready);
    end
    tick();
    exp_f = (a >= mdl_len);
    exp_d = exp_f ? '0 : mdl_mem[a];
    mdl_last = exp_d;
    checks++;
    if (f_valid !== 1'b1 || f_data !== exp_d || f_fault !== exp_f) begin
      failures++;
      $display("FAIL fetch addr=%0d got v=%0b d=%h f=%0b exp v=1 d=%h f=%0b",
               a, f_valid, f_data, f_fault, exp_d, exp_f);
    end
  endtask

  task automatic idle_check();
    f_req = 0;
    tick();
    checks++;
    if (f_valid !== 1'b0 || f_fault !== 1'b0 || f_data !== mdl_last) begin
      failures++;
      $display("FAIL idle got v=%0b f=%0b d=%h exp v=0 f=0 d=%h",
               f_valid, f_fault, f_data, mdl_last);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    Reset_n = 0;
    repeat (2) tick();
    checks++;
    if (busy !== 0 || plen !== '0 || f_valid !== 0 ||
        f_fault !== 0 || f_data !== '0) begin
      failures++;
      $display("FAIL reset_state busy=%0b plen=%0d v=%0b f=%0b d=%h exp all 0",
               busy, plen, f_valid, f_fault, f_data);
    end
    Reset_n = 1;
    tick();
    for (int n = 0; n < 3; n++) begin
      f_req = 1;
      f_addr = A'($urandom);
      #1;
      checks++;
      if (f_ready !== 1'b0) begin
        failures++;
        $display("FAIL reset_ready got=%0b exp=0", f_ready);
      end
      tick();
      checks++;
      if (f_valid !== 1'b0 || plen !== '0) begin
        failures++;
        $display("FAIL reset_fetch v=%0b plen=%0d exp v=0 plen=0",
                 f_valid, plen);
      end
    end
    f_req = 0;
  endtask

  task automatic test_basic();
    words = '{9'h1F0, 9'h0A5, 9'h123};
    do_load(1, 0);
    fetch(0);
    fetch(1);
    fetch(2);
    idle_check();
  endtask

  task automatic test_fault();
    fetch(3);
    idle_check();
    fetch(1);
    fetch(1023);
    idle_check();
  endtask

  task automatic test_restart();
    ld_start = 1;
    tick();
    ld_start = 0;
    ld_valid = 1;
    ld_data = 9'h111;
    tick();
    ld_data = 9'h122;
    tick();
    ld_start = 1;
    ld_data = 9'h1FF;
    tick();
    ld_start = 0;
    checks++;
    if (busy !== 1'b1 || plen !== '0) begin
      failures++;
      $display("FAIL restart_busy busy=%0b plen=%0d exp busy=1 plen=0",
               busy, plen);
    end
    ld_data = 9'h055;
    ld_last = 1;
    tick();
    ld_valid = 0;
    ld_last = 0;
    mdl_mem[0] = 9'h055;
    mdl_len = 1;
    checks++;
    if (busy !== 1'b0 || plen !== (A + 1)'(1)) begin
      failures++;
      $display("FAIL restart_len busy=%0b plen=%0d exp busy=0 plen=1",
               busy, plen);
    end
    fetch(0);
    fetch(1);
    idle_check();
  endtask

  task automatic test_loadstart_vs_fetch();
    f_req = 1;
    f_addr = '0;
    ld_start = 1;
    #1;
    checks++;
    if (f_ready !== 1'b0) begin
      failures++;
      $display("FAIL start_blocks_ready got=%0b exp=0", f_ready);
    end
    tick();
    ld_start = 0;
    f_req = 0;
    mdl_len = 0;
    checks++;
    if (f_valid !== 1'b0 || busy !== 1'b1 || plen !== '0) begin
      failures++;
      $display("FAIL start_wins v=%0b busy=%0b plen=%0d exp v=0 busy=1 plen=0",
               f_valid, busy, plen);
    end
    words = '{W'($urandom), W'($urandom)};
    do_load(1, 0);
    fetch(1);
    fetch(2);
  endtask

  task automatic test_back_to_back();
    int len;
    for (int r = 0; r < 6; r++) begin
      len = $urandom_range(1, 40);
      words.delete();
      for (int k = 0; k < len; k++) words.push_back(W'($urandom));
      do_load(1, 1);
      for (int n = 0; n < 40; n++) begin
        if ($urandom % 3 != 0) fetch($urandom_range(0, len + 3));
        else idle_check();
      end
      idle_check();
    end
  endtask

  task automatic test_overflow();
    logic [W-1:0] sw [5];
    for (int k = 0; k < 5; k++) sw[k] = W'($urandom);
    s_ld_start = 1;
    tick();
    s_ld_start = 0;
    for (int k = 0; k < 5; k++) begin
      s_ld_valid = 1;
      s_ld_data = sw[k];
      s_ld_last = 0;
      tick();
      if (k == 3) begin
        checks++;
        if (s_busy !== 1'b0 || s_plen !== 3'd4) begin
          failures++;
          $display("FAIL overflow_len busy=%0b plen=%0d exp busy=0 plen=4",
                   s_busy, s_plen);
        end
      end
    end
    s_ld_valid = 0;
    checks++;
    if (s_busy !== 1'b0 || s_plen !== 3'd4) begin
      failures++;
      $display("FAIL overflow_5th busy=%0b plen=%0d exp busy=0 plen=4",
               s_busy, s_plen);
    end
    for (int k = 3; k >= 0; k -= 3) begin
      s_f_req = 1;
      s_f_addr = SA'(k);
      tick();
      checks++;
      if (s_f_valid !== 1'b1 || s_f_data !== sw[k] || s_f_fault !== 1'b0) begin
        failures++;
        $display("FAIL overflow_fetch addr=%0d got v=%0b d=%h f=%0b exp v=1 d=%h f=0",
                 k, s_f_valid, s_f_data, s_f_fault, sw[k]);
      end
    end
    s_f_req = 0;
  endtask

  task automatic test_reset_async();
    ld_start = 1;
    tick();
    ld_start = 0;
    ld_valid = 1;
    ld_data = 9'h0F0;
    repeat (2) tick();
    #2;
    Reset_n = 0;
    #1;
    checks++;
    if (busy !== 0 || plen !== '0 || f_valid !== 0 ||
        f_fault !== 0 || f_data !== '0) begin
      failures++;
      $display("FAIL rst_midload busy=%0b plen=%0d v=%0b f=%0b d=%h exp all 0",
               busy, plen, f_valid, f_fault, f_data);
    end
    ld_valid = 0;
    tick();
    Reset_n = 1;
    mdl_len = 0;
    mdl_last = '0;
    f_req = 1;
    f_addr = '0;
    #1;
    checks++;
    if (f_ready !== 1'b0) begin
      failures++;
      $display("FAIL rst_empty_ready got=%0b exp=0", f_ready);
    end
    tick();
    checks++;
    if (f_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_empty v=%0b busy=%0b exp 0 0", f_valid, busy);
    end
    f_req = 0;
    words = '{9'h1F0, 9'h0A5};
    do_load(1, 0);
    fetch(0);
    f_req = 1;
    f_addr = A'(1);
    #2;
    Reset_n = 0;
    #1;
    checks++;
    if (busy !== 0 || plen !== '0 || f_valid !== 0 ||
        f_fault !== 0 || f_data !== '0 || f_ready !== 0) begin
      failures++;
      $display("FAIL rst_accept busy=%0b plen=%0d v=%0b f=%0b d=%h r=%0b exp all 0",
               busy, plen, f_valid, f_fault, f_data, f_ready);
    end
    tick();
    Reset_n = 1;
    mdl_len = 0;
    tick();
    checks++;
    if (f_valid !== 1'b0 || f_data !== '0) begin
      failures++;
      $display("FAIL rst_no_valid v=%0b d=%h exp v=0 d=0", f_valid, f_data);
    end
    f_req = 0;
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_basic();
    test_fault();
    test_restart();
    test_loadstart_vs_fetch();
    test_back_to_back();
    test_overflow();
    test_reset_async();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
